// File: rtl/ahb_sram_subordinate.sv
// AHB-Lite subordinate in front of a word-addressed SRAM array, with programmable
// wait states, byte strobes, two-cycle ERROR responses and write-to-read forwarding.
module ahb_sram_subordinate #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      HSEL,
  input  logic                      HREADY,
  input  logic [ADDR_WIDTH-1:0]     HADDR,
  input  logic [1:0]                HTRANS,
  input  logic                      HWRITE,
  input  logic [2:0]                HSIZE,
  input  logic [2:0]                HBURST,
  input  logic                      HMASTLOCK,
  input  logic [DATA_WIDTH-1:0]     HWDATA,
  input  logic [DATA_WIDTH/8-1:0]   HWSTRB,
  output logic                      HREADYOUT,
  output logic                      HRESP,
  output logic [DATA_WIDTH-1:0]     HRDATA
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int B  = $clog2(NB);
  localparam int IW = $clog2(DEPTH);

  // state | meaning
  // IDLE  | no data phase pending, zero-wait OKAY
  // WAIT  | OKAY data phase stalled, cnt_q cycles remain after this one
  // LAST  | final OKAY data phase cycle, transfer completes on the closing edge
  // ERR1  | first ERROR cycle, HREADYOUT low
  // ERR2  | second ERROR cycle, HREADYOUT high
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LAST, S_ERR1, S_ERR2} state_t;

  state_t                state_q;
  logic [3:0]            cnt_q;
  logic                  write_q;
  logic [IW-1:0]         idx_q;
  logic                  hreadyout_q;
  logic                  hresp_q;
  logic [DATA_WIDTH-1:0] hrdata_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  accept;
  logic [IW-1:0]         idx_in;
  logic                  range_err;
  logic                  size_err;
  logic                  align_err;
  logic                  err_in;
  logic                  wr_en;
  logic                  rd_load;
  logic [IW-1:0]         rd_idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  unused_ok;

  assign unused_ok = ^{HBURST, HMASTLOCK};

  assign accept = HSEL & HREADY & HTRANS[1] &
                  ((state_q == S_IDLE) | (state_q == S_LAST) | (state_q == S_ERR2));
  assign idx_in    = HADDR[IW+B-1:B];
  assign range_err = |HADDR[ADDR_WIDTH-1:IW+B];
  assign size_err  = HSIZE > 3'(B);

  always_comb begin
    align_err = 1'b0;
    for (int i = 0; i < B; i++) begin
      if ((HSIZE > 3'(i)) && HADDR[i]) align_err = 1'b1;
    end
  end

  assign err_in = range_err | size_err | align_err;
  assign wr_en  = (state_q == S_LAST) & write_q & ~HRESET;

  // Read data is captured on the edge that enters LAST: straight from the
  // address phase when there are no wait states, otherwise at the end of WAIT.
  assign rd_load = ((WAIT_STATES == 0) & accept & ~err_in & ~HWRITE) |
                   ((state_q == S_WAIT) & (cnt_q == 4'd0) & ~write_q);
  assign rd_idx  = (state_q == S_WAIT) ? idx_q : idx_in;

  always_comb begin
    rd_word = mem[rd_idx];
    if (wr_en && (idx_q == rd_idx)) begin
      for (int b = 0; b < NB; b++) begin
        if (HWSTRB[b]) rd_word[8*b +: 8] = HWDATA[8*b +: 8];
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (HWSTRB[b]) mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      write_q     <= 1'b0;
      idx_q       <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= '0;
    end else begin
      if (rd_load) hrdata_q <= rd_word;
      case (state_q)
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q     <= S_LAST;
            hreadyout_q <= 1'b1;
          end else begin
            cnt_q       <= cnt_q - 4'd1;
            hreadyout_q <= 1'b0;
          end
          hresp_q <= 1'b0;
        end
        S_ERR1: begin
          state_q     <= S_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b1;
        end
        default: begin
          if (accept) begin
            write_q <= HWRITE;
            idx_q   <= idx_in;
            if (err_in) begin
              state_q     <= S_ERR1;
              hreadyout_q <= 1'b0;
              hresp_q     <= 1'b1;
            end else if (WAIT_STATES > 0) begin
              state_q     <= S_WAIT;
              cnt_q       <= 4'(WAIT_STATES - 1);
              hreadyout_q <= 1'b0;
              hresp_q     <= 1'b0;
            end else begin
              state_q     <= S_LAST;
              hreadyout_q <= 1'b1;
              hresp_q     <= 1'b0;
            end
          end else begin
            state_q     <= S_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
          end
        end
      endcase
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = hrdata_q;

endmodule
